tugemm_nxn: RTL and testbench

- Parametrised successor of the fixed 8x8 temporal-unary GEMM core. Computes C = A x B for square NxN signed matrices.
- Elements of A are consumed as temporal-unary streams, one down-counter per row. Elements of B are applied in binary.
- Adds a start/busy/done handshake, result outputs, and data-dependent early termination per k-phase.
- Sits between the matrix load buffers and the result writeback / error-analysis logic.

---
 rtl/tugemm_nxn.sv | 161 ++++++++++++++++
 tb/tb_tugemm_nxn.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tugemm_nxn.sv
// tugemm_nxn: NxN signed GEMM, C = A x B. Each row of A is streamed as a
// temporal-unary down-counter per k-phase; B is applied in binary.
// Optional macro TUGEMM_CYCLE_COUNT_EN adds the cycle_count output.
module tugemm_nxn #(
  parameter int N     = 8,
  parameter int W     = 8,
  parameter int ACC_W = 2*W + $clog2(N)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [N*N*W-1:0]       vector_a,
  input  logic [N*N*W-1:0]       vector_b,
  output logic                   busy,
  output logic                   done,
  output logic [N*N*ACC_W-1:0]   result_c
`ifdef TUGEMM_CYCLE_COUNT_EN
  ,
  output logic [$clog2(N*(2**(W-1))):0] cycle_count
`endif
);

  localparam int KW = $clog2(N);
  localparam logic [KW-1:0] K_LAST = KW'(N-1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                    state_q, state_d;
  logic [N*N*W-1:0]          a_q, a_d, b_q, b_d;
  logic [KW-1:0]             k_q, k_d;
  logic [W-1:0]              cnt_q [N];
  logic [W-1:0]              cnt_d [N];
  logic                      s_q [N];
  logic                      s_d [N];
  logic signed [ACC_W-1:0]   acc_q [N*N];
  logic signed [ACC_W-1:0]   acc_d [N*N];
  logic [N*N*ACC_W-1:0]      res_q, res_d;
  logic                      phase_end;
  int unsigned               k_idx;

`ifdef TUGEMM_CYCLE_COUNT_EN
  logic [$clog2(N*(2**(W-1))):0] cc_q, cc_d;
  assign cycle_count = cc_q;
`endif

  // Magnitude as W-bit unsigned; -2^(W-1) maps exactly to 2^(W-1).
  function automatic logic [W-1:0] mag(input logic [W-1:0] x);
    return x[W-1] ? ('0 - x) : x;
  endfunction

  function automatic logic signed [ACC_W-1:0] sext(input logic [W-1:0] x);
    return {{(ACC_W-W){x[W-1]}}, x};
  endfunction

  assign k_idx    = 32'(k_q);
  assign busy     = (state_q == RUN);
  assign done     = (state_q == DONE);
  assign result_c = res_q;

  // Phase ends when no row needs more than the current cycle.
  always_comb begin
    phase_end = 1'b1;
    for (int unsigned i = 0; i < N; i++) begin
      if (cnt_q[i] > W'(1)) phase_end = 1'b0;
    end
  end

  // Next-state, datapath update and result capture.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    k_d     = k_q;
    res_d   = res_q;
    cnt_d   = cnt_q;
    s_d     = s_q;
    acc_d   = acc_q;
`ifdef TUGEMM_CYCLE_COUNT_EN
    cc_d    = cc_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          a_d = vector_a;
          b_d = vector_b;
          k_d = '0;
          for (int unsigned i = 0; i < N; i++) begin
            cnt_d[i] = mag(vector_a[(i*N)*W +: W]);
            s_d[i]   = vector_a[(i*N)*W + W - 1];
          end
          for (int unsigned m = 0; m < N*N; m++) acc_d[m] = '0;
`ifdef TUGEMM_CYCLE_COUNT_EN
          cc_d = '0;
`endif
          state_d = RUN;
        end
      end
      RUN: begin
`ifdef TUGEMM_CYCLE_COUNT_EN
        cc_d = cc_q + 1'b1;
`endif
        for (int unsigned i = 0; i < N; i++) begin
          if (cnt_q[i] != '0) begin
            for (int unsigned j = 0; j < N; j++) begin
              acc_d[i*N+j] = s_q[i] ? (acc_q[i*N+j] - sext(b_q[(k_idx*N+j)*W +: W]))
                                    : (acc_q[i*N+j] + sext(b_q[(k_idx*N+j)*W +: W]));
            end
            cnt_d[i] = cnt_q[i] - W'(1);
          end
        end
        if (phase_end) begin
          if (k_q == K_LAST) begin
            // Capture the final-cycle sums so result_c is valid with done.
            for (int unsigned m = 0; m < N*N; m++) res_d[m*ACC_W +: ACC_W] = acc_d[m];
            state_d = DONE;
          end else begin
            k_d = k_q + 1'b1;
            for (int unsigned i = 0; i < N; i++) begin
              cnt_d[i] = mag(a_q[(i*N + k_idx + 1)*W +: W]);
              s_d[i]   = a_q[(i*N + k_idx + 1)*W + W - 1];
            end
          end
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with asynchronous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      k_q     <= '0;
      res_q   <= '0;
      for (int unsigned i = 0; i < N; i++) begin
        cnt_q[i] <= '0;
        s_q[i]   <= 1'b0;
      end
      for (int unsigned m = 0; m < N*N; m++) acc_q[m] <= '0;
`ifdef TUGEMM_CYCLE_COUNT_EN
      cc_q    <= '0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      k_q     <= k_d;
      res_q   <= res_d;
      cnt_q   <= cnt_d;
      s_q     <= s_d;
      acc_q   <= acc_d;
`ifdef TUGEMM_CYCLE_COUNT_EN
      cc_q    <= cc_d;
`endif
    end
  end

endmodule

// File: tb/tb_tugemm_nxn.sv
// Self-checking bench for tugemm_nxn: reference matrix product and latency
// model feed a scoreboard queue, popped when done is observed.
module tb_tugemm_nxn;
  localparam int N     = 8;
  localparam int W     = 8;
  localparam int ACC_W = 2*W + $clog2(N);
  localparam int VW    = N*N*W;
  localparam int CW    = N*N*ACC_W;

  logic          clk = 1'b0;
  logic          rst, start;
  logic [VW-1:0] vector_a, vector_b;
  logic          busy, done;
  logic [CW-1:0] result_c;
`ifdef TUGEMM_CYCLE_COUNT_EN
  logic [$clog2(N*(2**(W-1))):0] cycle_count;
`endif

  tugemm_nxn #(.N(N), .W(W), .ACC_W(ACC_W)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .vector_a (vector_a),
    .vector_b (vector_b),
    .busy     (busy),
    .done     (done),
    .result_c (result_c)
`ifdef TUGEMM_CYCLE_COUNT_EN
    ,
    .cycle_count (cycle_count)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [CW-1:0] c;
    int            lat;
  } exp_t;
  exp_t sb[$];

  logic [VW-1:0] va, vb;

  function automatic logic [CW-1:0] model_c(input logic [VW-1:0] a, input logic [VW-1:0] b);
    logic [CW-1:0] r;
    logic [W-1:0]  ea, eb;
    int            s;
    r = '0;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        s = 0;
        for (int k = 0; k < N; k++) begin
          ea = a[(i*N+k)*W +: W];
          eb = b[(k*N+j)*W +: W];
          s += int'($signed(ea)) * int'($signed(eb));
        end
        r[(i*N+j)*ACC_W +: ACC_W] = ACC_W'(s);
      end
    return r;
  endfunction

  function automatic int model_lat(input logic [VW-1:0] a);
    int l, m, v;
    logic [W-1:0] e;
    l = 0;
    for (int k = 0; k < N; k++) begin
      m = 1;
      for (int i = 0; i < N; i++) begin
        e = a[(i*N+k)*W +: W];
        v = int'($signed(e));
        if (v < 0) v = -v;
        if (v > m) m = v;
      end
      l += m;
    end
    return l;
  endfunction

  // Push expectation, pulse start, then scramble inputs to prove latching.
  task automatic issue(input logic [VW-1:0] a, input logic [VW-1:0] b);
    exp_t e;
    e.c = model_c(a, b);
    e.lat = model_lat(a);
    sb.push_back(e);
    vector_a = a;
    vector_b = b;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    vector_a = ~a;
    vector_b = ~b;
  endtask

  // Bounded wait for done; optionally pulses start with other data at poke_at.
  task automatic wait_done(input int poke_at, output int lat, output int busy_bad);
    lat = -1;
    busy_bad = (busy !== 1'b1) ? 1 : 0;
    for (int c = 1; c <= 1100; c++) begin
      @(posedge clk); #1;
      start = 1'b0;
      if (done === 1'b1) begin
        lat = c;
        if (busy !== 1'b0) busy_bad++;
        break;
      end
      if (busy !== 1'b1) busy_bad++;
      if (c == poke_at) begin
        start = 1'b1;
        for (int i = 0; i < N*N; i++) vector_a[i*W +: W] = W'(8'hFF);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; vector_a = '0; vector_b = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL reset_ctrl busy=%b done=%b expected 0 0", busy, done);
    end
    checks++;
    if (result_c !== '0) begin
      errors++; $display("FAIL reset_result got %h expected 0", result_c);
    end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_identity();
    exp_t e; int lat, bb;
    va = '0;
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) begin
        if (r == c) va[(r*N+c)*W +: W] = W'(1);
        vb[(r*N+c)*W +: W] = W'(r*N + c - 32);
      end
    issue(va, vb);
    wait_done(0, lat, bb);
    e = sb.pop_front();
    checks++;
    if (lat !== e.lat || lat !== 8) begin
      errors++; $display("FAIL identity_latency got %0d expected %0d", lat, e.lat);
    end
    checks++;
    if (result_c !== e.c) begin
      errors++; $display("FAIL identity_result got %h expected %h", result_c, e.c);
    end
    checks++;
    if (bb !== 0) begin
      errors++; $display("FAIL identity_busy bad_cycles=%0d expected 0", bb);
    end
    @(posedge clk); #1;
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL identity_after done=%b busy=%b expected 0 0", done, busy);
    end
  endtask

  task automatic test_zero_a();
    exp_t e; int lat, bb;
    va = '0;
    for (int i = 0; i < N*N; i++) vb[i*W +: W] = W'($urandom);
    issue(va, vb);
    wait_done(0, lat, bb);
    e = sb.pop_front();
    checks++;
    if (lat !== e.lat || lat !== 8) begin
      errors++; $display("FAIL zero_latency got %0d expected %0d", lat, e.lat);
    end
    checks++;
    if (result_c !== '0) begin
      errors++; $display("FAIL zero_result got %h expected 0", result_c);
    end
`ifdef TUGEMM_CYCLE_COUNT_EN
    checks++;
    if (cycle_count !== 8) begin
      errors++; $display("FAIL zero_cycle_count got %0d expected 8", cycle_count);
    end
`endif
    @(posedge clk); #1;
  endtask

  task automatic test_start_ignored();
    exp_t e; int lat, bb, extra;
    va = '0; vb = '0;
    va[0 +: W] = W'(-3);
    vb[0 +: W] = W'(5);
    vb[W +: W] = W'(7);
    issue(va, vb);
    wait_done(4, lat, bb);
    e = sb.pop_front();
    checks++;
    if (lat !== e.lat || lat !== 10) begin
      errors++; $display("FAIL ignore_latency got %0d expected %0d", lat, e.lat);
    end
    checks++;
    if ($signed(result_c[0 +: ACC_W]) !== -15 || result_c !== e.c) begin
      errors++; $display("FAIL ignore_result got %h expected %h", result_c, e.c);
    end
    extra = 0;
    repeat (4) begin
      @(posedge clk); #1;
      if (done === 1'b1) extra++;
    end
    checks++;
    if (extra !== 0) begin
      errors++; $display("FAIL ignore_single_done extra_pulses=%0d expected 0", extra);
    end
  endtask

  task automatic test_extremes();
    exp_t e; int lat, bb;
    for (int p = 0; p < 2; p++) begin
      for (int i = 0; i < N*N; i++) begin
        va[i*W +: W] = (p == 0) ? W'(-128) : W'(127);
        vb[i*W +: W] = (p == 0) ? W'(-128) : W'(127);
      end
      issue(va, vb);
      wait_done(0, lat, bb);
      e = sb.pop_front();
      checks++;
      if (lat !== e.lat || lat !== ((p == 0) ? 1024 : 1016)) begin
        errors++; $display("FAIL extreme%0d_latency got %0d expected %0d", p, lat, e.lat);
      end
      checks++;
      if (result_c !== e.c || $signed(result_c[CW-1 -: ACC_W]) !== ((p == 0) ? 131072 : 129032)) begin
        errors++; $display("FAIL extreme%0d_result got %h expected %h", p, result_c, e.c);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_back_to_back();
    exp_t e1, e2; int lat, bb;
    logic [CW-1:0] first;
    for (int i = 0; i < N*N; i++) begin
      va[i*W +: W] = W'($urandom_range(6) - 3);
      vb[i*W +: W] = W'($urandom);
    end
    issue(va, vb);
    wait_done(0, lat, bb);
    e1 = sb.pop_front();
    first = result_c;
    checks++;
    if (lat !== e1.lat || result_c !== e1.c) begin
      errors++; $display("FAIL b2b_first lat=%0d/%0d result %h expected %h", lat, e1.lat, result_c, e1.c);
    end
    @(posedge clk); #1;
    for (int i = 0; i < N*N; i++) begin
      va[i*W +: W] = W'($urandom_range(10) - 5);
      vb[i*W +: W] = W'($urandom);
    end
    issue(va, vb);
    checks++;
    if (busy !== 1'b1 || result_c !== first) begin
      errors++; $display("FAIL b2b_accept busy=%b result %h expected busy 1 result %h", busy, result_c, first);
    end
    wait_done(0, lat, bb);
    e2 = sb.pop_front();
    checks++;
    if (lat !== e2.lat || result_c !== e2.c) begin
      errors++; $display("FAIL b2b_second lat=%0d/%0d result %h expected %h", lat, e2.lat, result_c, e2.c);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_abort();
    exp_t e; int lat, bb, seen;
    for (int i = 0; i < N*N; i++) begin
      va[i*W +: W] = W'(127);
      vb[i*W +: W] = W'(3);
    end
    issue(va, vb);
    repeat (4) begin @(posedge clk); #1; end
    rst = 1'b1;
    #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || result_c !== '0) begin
      errors++; $display("FAIL abort_reset busy=%b done=%b result %h expected all 0", busy, done, result_c);
    end
    void'(sb.pop_back());
    repeat (3) @(posedge clk);
    #1; rst = 1'b0;
    seen = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (done === 1'b1 || busy === 1'b1) seen++;
    end
    checks++;
    if (seen !== 0) begin
      errors++; $display("FAIL abort_no_done active_cycles=%0d expected 0", seen);
    end
    for (int i = 0; i < N*N; i++) begin
      va[i*W +: W] = W'($urandom_range(4) - 2);
      vb[i*W +: W] = W'($urandom);
    end
    issue(va, vb);
    wait_done(0, lat, bb);
    e = sb.pop_front();
    checks++;
    if (lat !== e.lat || result_c !== e.c || bb !== 0) begin
      errors++; $display("FAIL abort_new_op lat=%0d/%0d busy_bad=%0d result %h expected %h", lat, e.lat, bb, result_c, e.c);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_identity();
    test_zero_a();
    test_start_ignored();
    test_extremes();
    test_back_to_back();
    test_reset_abort();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
